// File: rtl/pico_ctrl_pkg.sv
// rtl/pico_ctrl_pkg.sv - shared types and constants for the picoMIPS run controller
package pico_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STEP    = 2'd2,
        STOPPED = 2'd3
    } run_state_t;

    localparam int INSTR_CNT_W = 16;

endpackage

// File: rtl/pico_debounce.sv
// rtl/pico_debounce.sv - two-flop synchroniser followed by a persistence-counter debouncer
module pico_debounce #(
    parameter int DB_W = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam logic [DB_W-1:0] DB_MAX = '1;

    logic            s1;
    logic            s2;
    logic [DB_W-1:0] cnt;

    // dout only follows s2 once it has differed for DB_MAX+1 consecutive cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == dout) begin
                cnt <= '0;
            end else if (cnt == DB_MAX) begin
                dout <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pico_run_ctrl.sv
// rtl/pico_run_ctrl.sv - single-clock run/step/halt controller producing the core clock enable
module pico_run_ctrl
    import pico_ctrl_pkg::*;
#(
    parameter int PRE_W = 24,
    parameter int DB_W  = 16,
    parameter int XW    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run_sw,
    input  logic                   step_btn,
    input  logic                   bstus_raw,
    input  logic [XW-1:0]          sw_raw,
    input  logic                   cpu_halt,
    output logic                   cpu_en,
    output logic                   bstus,
    output logic [XW-1:0]          x_out,
    output logic [1:0]             run_state,
    output logic [INSTR_CNT_W-1:0] instr_cnt
);

    localparam logic [PRE_W-1:0]       PRE_MAX = '1;
    localparam logic [INSTR_CNT_W-1:0] CNT_MAX = '1;

    logic                   db_run;
    logic                   db_step;
    logic                   db_step_q;
    logic                   step_rise;
    logic                   tick;
    logic                   en_d;
    logic [XW-1:0]          sw_s1;
    logic [XW-1:0]          sw_s2;
    logic [PRE_W-1:0]       pre_q;
    logic [PRE_W-1:0]       pre_d;
    logic [INSTR_CNT_W-1:0] cnt_q;
    run_state_t             state_q;
    run_state_t             state_d;

    pico_debounce #(.DB_W(DB_W)) u_db_run (
        .clk   (clk),
        .reset (reset),
        .din   (run_sw),
        .dout  (db_run)
    );

    pico_debounce #(.DB_W(DB_W)) u_db_step (
        .clk   (clk),
        .reset (reset),
        .din   (step_btn),
        .dout  (db_step)
    );

    pico_debounce #(.DB_W(DB_W)) u_db_bstus (
        .clk   (clk),
        .reset (reset),
        .din   (bstus_raw),
        .dout  (bstus)
    );

    assign step_rise = db_step & ~db_step_q;
    assign tick      = (pre_q == PRE_MAX);

    // halt outranks a run drop, which outranks a prescaler tick
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        en_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_halt) begin
                    state_d = STOPPED;
                end else if (db_run) begin
                    state_d = RUN;
                    pre_d   = '0;
                end else if (step_rise) begin
                    state_d = STEP;
                    en_d    = 1'b1;
                end
            end
            STEP: begin
                state_d = IDLE;
            end
            RUN: begin
                pre_d = pre_q + 1'b1;
                if (cpu_halt) begin
                    state_d = STOPPED;
                end else if (!db_run) begin
                    state_d = IDLE;
                end else if (tick) begin
                    en_d = 1'b1;
                end
            end
            STOPPED: begin
                if (!db_run && !cpu_halt) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            cpu_en    <= 1'b0;
            db_step_q <= 1'b0;
            sw_s1     <= '0;
            sw_s2     <= '0;
            x_out     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            cpu_en    <= en_d;
            db_step_q <= db_step;
            sw_s1     <= sw_raw;
            sw_s2     <= sw_s1;
            // switch data is held steady for the core while it executes
            if (state_q == IDLE || state_q == STOPPED) begin
                x_out <= sw_s2;
            end
            if (cpu_en && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign run_state = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_pico_run_ctrl.sv
// tb/tb_pico_run_ctrl.sv - randomized self-checking bench for pico_run_ctrl
module tb_pico_run_ctrl;

    localparam int PRE_W = 3;
    localparam int DB_W  = 2;
    localparam int XW    = 8;
    localparam int PERIOD  = 1 << PRE_W;
    localparam int DB_MAX  = (1 << DB_W) - 1;
    localparam int RUN_LAT = DB_MAX + 4;
    localparam int STEP_LAT = DB_MAX + 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run_sw = 1'b0;
    logic          step_btn = 1'b0;
    logic          bstus_raw = 1'b0;
    logic [XW-1:0] sw_raw = '0;
    logic          cpu_halt = 1'b0;
    logic          cpu_en;
    logic          bstus;
    logic [XW-1:0] x_out;
    logic [1:0]    run_state;
    logic [15:0]   instr_cnt;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          pulse_q[$];
    logic        prev_en = 1'b0;
    logic [15:0] exp_cnt = 16'd0;
    logic [7:0]  sw_val = 8'd0;

    pico_run_ctrl #(.PRE_W(PRE_W), .DB_W(DB_W), .XW(XW)) dut (
        .clk       (clk),
        .reset     (reset),
        .run_sw    (run_sw),
        .step_btn  (step_btn),
        .bstus_raw (bstus_raw),
        .sw_raw    (sw_raw),
        .cpu_halt  (cpu_halt),
        .cpu_en    (cpu_en),
        .bstus     (bstus),
        .x_out     (x_out),
        .run_state (run_state),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // pulse log plus saturating reference count of every enable the core receives
    always @(negedge clk) begin
        if (!reset) begin
            check_eq("en_gap", 32'(cpu_en & prev_en), 32'd0);
            if (cpu_en) begin
                pulse_q.push_back(cyc);
                if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            end
        end
        prev_en = cpu_en;
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_run(input int len);
        int c, d, n;
        logic [7:0] old_sw, new_sw;
        c = cyc;
        old_sw = sw_val;
        pulse_q.delete();
        run_sw = 1'b1;
        wait_until(c + 10);
        check_eq("run_state_run", 32'(run_state), 32'd1);
        new_sw = 8'($urandom);
        sw_raw = new_sw;
        sw_val = new_sw;
        wait_until(c + len);
        d = cyc;
        check_eq("x_frozen", 32'(x_out), 32'(old_sw));
        run_sw = 1'b0;
        wait_until(d + 10);
        check_eq("run_state_idle", 32'(run_state), 32'd0);
        check_eq("x_reload", 32'(x_out), 32'(new_sw));
        // last pulse is allowed while the debounced run level is still high
        n = (d + DB_MAX + 3 - (c + RUN_LAT + PERIOD)) / PERIOD + 1;
        check_eq("run_pulses", 32'(pulse_q.size()), 32'(n));
        if (pulse_q.size() > 0) begin
            check_eq("run_first", 32'(pulse_q[0]), 32'(c + RUN_LAT + PERIOD));
            check_eq("run_last", 32'(pulse_q[$]), 32'(c + RUN_LAT + PERIOD * pulse_q.size()));
        end
        check_eq("run_cnt", 32'(instr_cnt), 32'(exp_cnt));
    endtask

    task automatic do_step(input int len);
        int c;
        c = cyc;
        pulse_q.delete();
        step_btn = 1'b1;
        wait_cyc(len);
        step_btn = 1'b0;
        wait_cyc(12);
        if (len > DB_MAX) begin
            check_eq("step_one", 32'(pulse_q.size()), 32'd1);
            if (pulse_q.size() > 0)
                check_eq("step_time", 32'(pulse_q[0]), 32'(c + STEP_LAT));
        end else begin
            check_eq("step_glitch", 32'(pulse_q.size()), 32'd0);
        end
        check_eq("step_cnt", 32'(instr_cnt), 32'(exp_cnt));
    endtask

    task automatic do_halt(input int m);
        int c;
        c = cyc;
        pulse_q.delete();
        run_sw = 1'b1;
        wait_until(c + RUN_LAT + PERIOD - 1 + PERIOD * m);
        cpu_halt = 1'b1;
        wait_until(c + RUN_LAT + PERIOD + PERIOD * m);
        check_eq("halt_state", 32'(run_state), 32'd3);
        check_eq("halt_no_en", 32'(cpu_en), 32'd0);
        wait_cyc(2);
        check_eq("halt_pulses", 32'(pulse_q.size()), 32'(m));
        run_sw = 1'b0;
        wait_cyc(12);
        check_eq("halt_hold", 32'(run_state), 32'd3);
        cpu_halt = 1'b0;
        wait_cyc(1);
        check_eq("halt_release", 32'(run_state), 32'd0);
        check_eq("halt_cnt", 32'(instr_cnt), 32'(exp_cnt));
    endtask

    initial begin
        int hit;
        logic [7:0] v;
        wait_cyc(2);
        check_eq("rst_en", 32'(cpu_en), 32'd0);
        check_eq("rst_bstus", 32'(bstus), 32'd0);
        check_eq("rst_x", 32'(x_out), 32'd0);
        check_eq("rst_state", 32'(run_state), 32'd0);
        check_eq("rst_cnt", 32'(instr_cnt), 32'd0);
        reset = 1'b0;
        wait_cyc(2);

        for (int i = 0; i < 3; i++) begin
            v = 8'($urandom);
            sw_raw = v;
            sw_val = v;
            wait_cyc(4);
            check_eq("x_idle", 32'(x_out), 32'(v));
        end

        do_run($urandom_range(193, 200));
        check_eq("cnt_24", 32'(instr_cnt), 32'd24);
        for (int i = 0; i < 3; i++) do_run($urandom_range(20, 120));

        for (int i = 0; i < 4; i++) do_step($urandom_range(DB_MAX + 1, 30));
        for (int i = 0; i < 3; i++) do_step($urandom_range(1, DB_MAX));

        bstus_raw = 1'b1;
        wait_cyc($urandom_range(1, DB_MAX));
        bstus_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bstus_glitch", 32'(bstus), 32'd0);
        end
        bstus_raw = 1'b1;
        wait_cyc(10);
        check_eq("bstus_hi", 32'(bstus), 32'd1);
        bstus_raw = 1'b0;
        wait_cyc(10);
        check_eq("bstus_lo", 32'(bstus), 32'd0);

        do_halt(0);
        do_halt($urandom_range(1, 2));

        force dut.cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_q;
        exp_cnt = 16'hFFFE;
        wait_cyc(2);
        for (int i = 0; i < 3; i++) do_step($urandom_range(DB_MAX + 1, 10));
        check_eq("cnt_sat", 32'(instr_cnt), 32'h0000FFFF);

        run_sw = 1'b1;
        hit = 0;
        for (int i = 0; i < 40 && hit == 0; i++) begin
            @(negedge clk);
            if (cpu_en) hit = 1;
        end
        check_eq("rst_pulse_seen", 32'(hit), 32'd1);
        reset = 1'b1;
        run_sw = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_en", 32'(cpu_en), 32'd0);
        check_eq("mid_rst_state", 32'(run_state), 32'd0);
        check_eq("mid_rst_cnt", 32'(instr_cnt), 32'd0);
        check_eq("mid_rst_x", 32'(x_out), 32'd0);
        check_eq("mid_rst_bstus", 32'(bstus), 32'd0);
        exp_cnt = 16'd0;
        reset = 1'b0;
        wait_cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
